demux_fifo_router: RTL
======================

Name: demux_fifo_router

Overview:
- Parametrised successor to the 4-way class demux.
- Routes each input word to one of NUM_CH output channels. The channel is selected by the class field, which is the top CLASS_W bits of the word.
- Each channel has its own DEPTH-entry FIFO with valid/pop handshakes, so a stalled consumer does not corrupt or drop data.
- Sits between the upstream class-tagged data source and the per-class consumers.

Parameters:
- DATA_W, 12, width of one data word; the class field is data_in[DATA_W-1 -: CLASS_W].
- NUM_CH, 4, number of output channels; must be a power of two, minimum 2.
- DEPTH, 4, entries per channel FIFO; must be a power of two, minimum 2.
- AF_THRESH, 3, occupancy at or above which almost_full[i] asserts; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  input word; the top CLASS_W bits select the channel.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  combinational; 1 when the FIFO addressed by data_in's class is not full.
- pop  input  NUM_CH  per-channel consumer acknowledge for the head word.
- data_out  output  NUM_CH*DATA_W  packed head words; channel i occupies slice [i*DATA_W +: DATA_W].
- valid_out  output  NUM_CH  per-channel "head word present" (FIFO non-empty).
- almost_full  output  NUM_CH  per-channel occupancy >= AF_THRESH.
- count  output  NUM_CH*(log2(DEPTH)+1)  packed per-channel occupancy.

Behaviour:
- CLASS_W = log2(NUM_CH); cls = data_in[DATA_W-1 -: CLASS_W]. The full word, including the class bits, is stored.
- Push condition: push happens when valid_in && ready_out, into FIFO[cls] only.
  - When valid_in && !ready_out, the word is not accepted.
  - Upstream must hold data_in and valid_in until accepted. The block never drops words.
- ready_out = !full[cls], evaluated even when valid_in=0.
  - There is no full-with-pop bypass: a full FIFO refuses the push even if pop[cls] is asserted the same cycle.
- Outputs are show-ahead:
  - valid_out[i] = (count_i != 0).
  - data_out slice i = head word when valid_out[i]=1; forced to 0 when empty.
- Latency: a word pushed at edge N appears on data_out/valid_out right after edge N (visible in cycle N+1). There is no combinational input-to-output path.
- Pop: pop[i] && valid_out[i] removes the head at the next edge. pop[i] on an empty channel is ignored (no underflow, count stays 0).
- Simultaneous push and pop on the same non-full, non-empty channel: both take effect and the count is unchanged.
  - Pushing into an empty channel while popping it: the pop is ignored and the push succeeds.
- Channels are fully independent: pushes and pops on different channels in the same cycle all occur.
- Pointers: log2(DEPTH)-bit read and write pointers per FIFO, wrapping modulo DEPTH. The count is kept separately, with range 0..DEPTH.
- almost_full[i] = (count_i >= AF_THRESH). It is advisory only; ready_out uses the full condition.
- FIFO order: strict per-channel order is required. There is no ordering guarantee across channels.
- Reset (asynchronous, any time including mid-transfer):
  - all pointers and counts go to 0;
  - valid_out, almost_full, count and data_out go to 0;
  - ready_out becomes 1;
  - stored contents are discarded.
  - The storage array itself need not be reset.
- After reset deassertion, the first push is accepted at the first rising edge.

Decomposition:
- Package demux_pkg:
  - clog2-style width function;
  - default DATA_W, NUM_CH, DEPTH constants;
  - CLASS_W derivation;
  - count-width constant.
- Sub-module demux_chan_fifo (parameters DATA_W, DEPTH, AF_THRESH):
  - ports: clk, reset_L, push, wdata, pop, rdata, valid, full, almost_full, count.
  - The top level instantiates it NUM_CH times in a generate loop and adds class decode, ready_out mux and output packing.

Test Plan (DATA_W=12, NUM_CH=4, DEPTH=4, AF_THRESH=3):
1. Reset: assert reset_L=0 mid-simulation with ch1 holding 2 words -> immediately valid_out=4'b0000, count all 0, data_out=0, ready_out=1.
2. Single route: push 12'h405 (class 01) -> after next edge valid_out=4'b0010, data_out slice1=12'h405, all other slices 0; pop[1]=1 for one cycle -> valid_out=4'b0000.
3. Full/backpressure: push 12'h800..12'h803 to ch2 -> almost_full[2]=1 after the 3rd push, count2=4.
   - Presenting 12'h804 gives ready_out=0 and no count change.
   - pop[2]=1 for one cycle -> ready_out=1, then 12'h804 is accepted.
   - Subsequent pops yield 801, 802, 803, 804 in order (wrap-around exercised).
4. Simultaneous push and pop: with ch3 holding 12'hC01, push 12'hC02 while pop[3]=1 -> count3 stays 1, head becomes 12'hC02.
5. Underflow and independence: pop=4'b1111 with all channels empty -> counts stay 0. Then push 12'h001 to ch0 while pop[1]=1 on empty ch1 -> only ch0 becomes valid.
6. Full-with-pop: ch0 full with 12'h010..12'h013; present 12'h014 with pop[0]=1 -> 12'h014 is not accepted that cycle, count0 drops to 3, and 12'h014 is accepted on the next cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg : shared constants and width helpers for the class-demux router
// Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_AF_THRESH = 3;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int demux_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int DEF_CLASS_W = demux_clog2(DEF_NUM_CH);
  localparam int DEF_CNT_W   = demux_clog2(DEF_DEPTH) + 1;

endpackage

`default_nettype wire

// File: rtl/demux_chan_fifo.sv
// ============================================================================
// demux_chan_fifo : show-ahead per-channel FIFO with separate occupancy count
// Revision        : 1.0
// ============================================================================
`default_nettype none

module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         valid,
  output logic                         full,
  output logic                         almost_full,
  output logic [demux_clog2(DEPTH):0]  count
);

  localparam int PTR_W = demux_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign valid       = (count_q != '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign rdata       = valid ? mem_q[rd_ptr_q] : '0;

  // A full FIFO refuses a push even when popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an empty FIFO masks it on rdata.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/demux_fifo_router.sv
// ============================================================================
// demux_fifo_router : routes class-tagged words into NUM_CH independent FIFOs
// Revision          : 1.0
// ============================================================================
`default_nettype none

module demux_fifo_router
  import demux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic                                     clk,
  input  logic                                     reset_L,
  input  logic [DATA_W-1:0]                        data_in,
  input  logic                                     valid_in,
  output logic                                     ready_out,
  input  logic [NUM_CH-1:0]                        pop,
  output logic [NUM_CH*DATA_W-1:0]                 data_out,
  output logic [NUM_CH-1:0]                        valid_out,
  output logic [NUM_CH-1:0]                        almost_full,
  output logic [NUM_CH*(demux_clog2(DEPTH)+1)-1:0] count
);

  localparam int CLASS_W = demux_clog2(NUM_CH);
  localparam int CNT_W   = demux_clog2(DEPTH) + 1;

  logic [CLASS_W-1:0] cls;
  logic [NUM_CH-1:0]  full;
  logic [NUM_CH-1:0]  push;

  assign cls       = data_in[DATA_W-1 -: CLASS_W];
  assign ready_out = !full[cls];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign push[i] = valid_in && ready_out && (cls == CLASS_W'(i));

    demux_chan_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset_L     (reset_L),
      .push        (push[i]),
      .wdata       (data_in),
      .pop         (pop[i]),
      .rdata       (data_out[i*DATA_W +: DATA_W]),
      .valid       (valid_out[i]),
      .full        (full[i]),
      .almost_full (almost_full[i]),
      .count       (count[i*CNT_W +: CNT_W])
    );
  end

endmodule

`default_nettype wire
